// File: rtl/riscv_pkg.sv
// Shared core parameters plus the program-loader state type and error codes.
package riscv_pkg;

    localparam int          IMEM_SIZE = 16;
    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    localparam logic [7:0]  LOADER_SYNC_BYTE = 8'hA5;
    localparam logic [1:0]  LOADER_ERR_NONE  = 2'b00;
    localparam logic [1:0]  LOADER_ERR_LEN   = 2'b01;
    localparam logic [1:0]  LOADER_ERR_CSUM  = 2'b10;

    typedef enum logic [3:0] {
        LD_IDLE,
        LD_SYNC,
        LD_LEN0,
        LD_LEN1,
        LD_DATA,
        LD_CSUM,
        LD_FILL,
        LD_DONE,
        LD_ERROR
    } loader_state_t;

endpackage

// File: rtl/prog_loader_word_asm.sv
// Little-endian byte-to-word assembler; word_valid_o flags the byte that completes a word.
module loader_word_asm (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        clear_i,
    input  logic        byte_valid_i,
    input  logic [7:0]  byte_i,
    output logic        word_valid_o,
    output logic [31:0] word_o
);

    logic [1:0]  cnt_q, cnt_d;
    logic [23:0] shift_q, shift_d;

    always_comb begin
        cnt_d        = cnt_q;
        shift_d      = shift_q;
        word_valid_o = 1'b0;
        word_o       = {byte_i, shift_q};
        if (clear_i) begin
            cnt_d   = 2'd0;
            shift_d = 24'd0;
        end else if (byte_valid_i) begin
            cnt_d        = cnt_q + 2'd1;
            shift_d      = {byte_i, shift_q[23:8]};
            word_valid_o = (cnt_q == 2'd3);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q   <= 2'd0;
            shift_q <= 24'd0;
        end else begin
            cnt_q   <= cnt_d;
            shift_q <= shift_d;
        end
    end

endmodule

// File: rtl/prog_loader.sv
// Program loader: takes a framed byte stream, writes instruction words into imem,
// pads the rest with NOPs and releases the core only after a matching checksum.
//
// state | meaning
// IDLE  | waiting for start after reset
// SYNC  | discarding bytes until the sync marker
// LEN0  | low byte of word count
// LEN1  | high byte of word count, range check
// DATA  | payload bytes, one imem write per 4 bytes
// CSUM  | compare XOR of payload bytes
// FILL  | NOP writes from N to the top of imem
// DONE  | load good, core released
// ERROR | load aborted, core held
module prog_loader
    import riscv_pkg::*;
#(
    parameter int IMEM_WORDS = IMEM_SIZE,
    parameter int ADDR_W     = $clog2(IMEM_WORDS)
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              start,
    input  logic              s_valid,
    input  logic [7:0]        s_data,
    output logic              s_ready,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [31:0]       imem_wdata,
    output logic              core_hold,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [1:0]        err_code,
    output logic [ADDR_W:0]   words_loaded
);

    localparam logic [15:0]   DEPTH16  = 16'(IMEM_WORDS);
    localparam logic [ADDR_W:0] DEPTH  = (ADDR_W+1)'(IMEM_WORDS);
    localparam logic [ADDR_W:0] ONE    = {{ADDR_W{1'b0}}, 1'b1};

    loader_state_t     state_q, state_d;
    logic [15:0]       len_q, len_d, len_n;
    logic [7:0]        csum_q, csum_d;
    logic [ADDR_W:0]   words_q, words_d;
    logic [ADDR_W:0]   fill_q, fill_d;
    logic [1:0]        err_code_q, err_code_d;
    logic              we_q, we_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [31:0]       wdata_q, wdata_d;
    logic              fire, asm_clear, asm_valid, word_valid;
    logic [31:0]       word;

    assign s_ready = (state_q == LD_SYNC) || (state_q == LD_LEN0) || (state_q == LD_LEN1) ||
                     (state_q == LD_DATA) || (state_q == LD_CSUM);
    assign fire      = s_valid && s_ready;
    assign asm_valid = fire && (state_q == LD_DATA);
    assign len_n     = {s_data, len_q[7:0]};

    loader_word_asm u_word_asm (
        .clk          (clk),
        .reset_n      (reset_n),
        .clear_i      (asm_clear),
        .byte_valid_i (asm_valid),
        .byte_i       (s_data),
        .word_valid_o (word_valid),
        .word_o       (word)
    );

    always_comb begin
        state_d    = state_q;
        len_d      = len_q;
        csum_d     = csum_q;
        words_d    = words_q;
        fill_d     = fill_q;
        err_code_d = err_code_q;
        we_d       = 1'b0;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        asm_clear  = 1'b0;
        case (state_q)
            LD_IDLE, LD_DONE, LD_ERROR: begin
                if (start) begin
                    state_d    = LD_SYNC;
                    words_d    = '0;
                    csum_d     = 8'd0;
                    err_code_d = LOADER_ERR_NONE;
                    asm_clear  = 1'b1;
                end
            end
            LD_SYNC: if (fire && s_data == LOADER_SYNC_BYTE) state_d = LD_LEN0;
            LD_LEN0: begin
                if (fire) begin
                    len_d[7:0] = s_data;
                    state_d    = LD_LEN1;
                end
            end
            LD_LEN1: begin
                if (fire) begin
                    len_d = len_n;
                    if (len_n > DEPTH16) begin
                        state_d    = LD_ERROR;
                        err_code_d = LOADER_ERR_LEN;
                    end else if (len_n == 16'd0) begin
                        state_d = LD_CSUM;
                    end else begin
                        state_d = LD_DATA;
                    end
                end
            end
            LD_DATA: begin
                if (fire) csum_d = csum_q ^ s_data;
                if (word_valid) begin
                    we_d    = 1'b1;
                    addr_d  = words_q[ADDR_W-1:0];
                    wdata_d = word;
                    words_d = words_q + ONE;
                    if (16'(words_q) + 16'd1 == len_q) state_d = LD_CSUM;
                end
            end
            LD_CSUM: begin
                if (fire) begin
                    if (s_data == csum_q) begin
                        fill_d  = words_q;
                        state_d = (words_q == DEPTH) ? LD_DONE : LD_FILL;
                    end else begin
                        state_d    = LD_ERROR;
                        err_code_d = LOADER_ERR_CSUM;
                    end
                end
            end
            LD_FILL: begin
                we_d    = 1'b1;
                addr_d  = fill_q[ADDR_W-1:0];
                wdata_d = NOP_INSTR;
                fill_d  = fill_q + ONE;
                if (fill_q + ONE == DEPTH) state_d = LD_DONE;
            end
            default: state_d = LD_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= LD_IDLE;
            len_q      <= 16'd0;
            csum_q     <= 8'd0;
            words_q    <= '0;
            fill_q     <= '0;
            err_code_q <= LOADER_ERR_NONE;
            we_q       <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= 32'd0;
        end else begin
            state_q    <= state_d;
            len_q      <= len_d;
            csum_q     <= csum_d;
            words_q    <= words_d;
            fill_q     <= fill_d;
            err_code_q <= err_code_d;
            we_q       <= we_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
        end
    end

    assign imem_we      = we_q;
    assign imem_addr    = addr_q;
    assign imem_wdata   = wdata_q;
    assign busy         = !((state_q == LD_IDLE) || (state_q == LD_DONE) || (state_q == LD_ERROR));
    assign done         = (state_q == LD_DONE);
    assign err          = (state_q == LD_ERROR);
    assign core_hold    = (state_q != LD_DONE);
    assign err_code     = err_code_q;
    assign words_loaded = words_q;

endmodule

// File: tb/tb_prog_loader.sv
// Scoreboard bench for prog_loader: a frame-level model predicts imem writes and final status.
module tb_prog_loader;
    import riscv_pkg::*;

    localparam int          W   = IMEM_SIZE;
    localparam int          AW  = $clog2(W);
    localparam logic [31:0] NOP = 32'h0000_0013;

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic          start = 1'b0;
    logic          s_valid = 1'b0;
    logic [7:0]    s_data = 8'd0;
    logic          s_ready, imem_we, core_hold, busy, done, err;
    logic [AW-1:0] imem_addr;
    logic [31:0]   imem_wdata;
    logic [1:0]    err_code;
    logic [AW:0]   words_loaded;

    prog_loader dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .start        (start),
        .s_valid      (s_valid),
        .s_data       (s_data),
        .s_ready      (s_ready),
        .imem_we      (imem_we),
        .imem_addr    (imem_addr),
        .imem_wdata   (imem_wdata),
        .core_hold    (core_hold),
        .busy         (busy),
        .done         (done),
        .err          (err),
        .err_code     (err_code),
        .words_loaded (words_loaded)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    typedef struct {
        int          addr;
        logic [31:0] data;
    } wr_t;
    typedef logic [7:0] bq_t[$];

    wr_t         exp_q[$];
    logic [31:0] em[W];
    logic [31:0] am[W];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h expected=%h t=%0t", name, act, exp, $time);
        end
    endtask

    // Monitor: every imem write must match the head of the expected-write queue.
    always @(negedge clk) begin
        if (reset_n && imem_we) begin
            am[imem_addr] = imem_wdata;
            if (exp_q.size() == 0) begin
                chk("unexpected_write_addr", 32'(imem_addr), 32'hFFFF_FFFF);
            end else begin
                wr_t e;
                e = exp_q.pop_front();
                chk("write_addr", 32'(imem_addr), 32'(e.addr));
                chk("write_data", imem_wdata, e.data);
            end
        end
    end

    // Reference: walk the byte stream by frame rules and predict writes and outcome.
    task automatic model(input bq_t b, output bit complete, output bit m_done, output bit m_err,
                         output logic [1:0] m_code, output int m_words, output int m_lat);
        int i;
        int n;
        logic [7:0]  x;
        logic [31:0] w;
        i = 0; x = 8'd0;
        complete = 0; m_done = 0; m_err = 0; m_code = 2'b00; m_words = 0; m_lat = 0;
        while (i < b.size() && b[i] != 8'hA5) i++;
        if (i + 3 > b.size()) return;
        n = int'({b[i+2], b[i+1]});
        i += 3;
        if (n > W) begin
            complete = 1; m_err = 1; m_code = 2'b01;
            return;
        end
        for (int k = 0; k < n; k++) begin
            if (i + 4 > b.size()) return;
            w = {b[i+3], b[i+2], b[i+1], b[i]};
            x = x ^ b[i] ^ b[i+1] ^ b[i+2] ^ b[i+3];
            exp_q.push_back('{k, w});
            em[k] = w;
            m_words++;
            i += 4;
        end
        if (i >= b.size()) return;
        complete = 1;
        if (b[i] != x) begin
            m_err = 1; m_code = 2'b10;
            return;
        end
        for (int a = n; a < W; a++) begin
            exp_q.push_back('{a, NOP});
            em[a] = NOP;
        end
        m_done = 1;
        m_lat  = W - n;
    endtask

    task automatic pulse_start();
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        @(negedge clk);
        chk("start_core_hold", 32'(core_hold), 32'd1);
        chk("start_done", 32'(done), 32'd0);
        chk("start_busy", 32'(busy), 32'd1);
    endtask

    task automatic send_byte(input logic [7:0] b, input int gap, input bit with_start);
        int guard;
        guard = 0;
        repeat (gap) @(negedge clk);
        @(negedge clk);
        s_valid = 1'b1;
        s_data  = b;
        start   = with_start;
        while (!s_ready && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        if (!s_ready) chk("ready_timeout", 32'(s_ready), 32'd1);
        @(posedge clk);
        #1;
        s_valid = 1'b0;
        start   = 1'b0;
    endtask

    task automatic run_frame(input string tag, input bq_t b, input int mingap, input int maxgap,
                             input int start_at);
        bit         complete, m_done, m_err;
        logic [1:0] m_code;
        int         m_words, m_lat, lat;
        model(b, complete, m_done, m_err, m_code, m_words, m_lat);
        pulse_start();
        foreach (b[k]) send_byte(b[k], int'($urandom_range(maxgap, mingap)), (k == start_at));
        if (!complete) return;
        lat = 0;
        @(negedge clk);
        while (!done && !err && lat < 200) begin
            @(negedge clk);
            lat++;
        end
        chk({tag, "_latency"}, 32'(lat), 32'(m_lat));
        chk({tag, "_done"}, 32'(done), 32'(m_done));
        chk({tag, "_err"}, 32'(err), 32'(m_err));
        chk({tag, "_err_code"}, 32'(err_code), 32'(m_code));
        chk({tag, "_core_hold"}, 32'(core_hold), 32'(!m_done));
        chk({tag, "_words"}, 32'(words_loaded), 32'(m_words));
        chk({tag, "_busy"}, 32'(busy), 32'd0);
        @(posedge clk);
        #1;
        chk({tag, "_pending_writes"}, 32'(exp_q.size()), 32'd0);
        for (int a = 0; a < W; a++) chk({tag, "_mem"}, am[a], em[a]);
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_s_ready"}, 32'(s_ready), 32'd0);
        chk({tag, "_imem_we"}, 32'(imem_we), 32'd0);
        chk({tag, "_imem_addr"}, 32'(imem_addr), 32'd0);
        chk({tag, "_imem_wdata"}, imem_wdata, 32'd0);
        chk({tag, "_core_hold"}, 32'(core_hold), 32'd1);
        chk({tag, "_busy"}, 32'(busy), 32'd0);
        chk({tag, "_done"}, 32'(done), 32'd0);
        chk({tag, "_err"}, 32'(err), 32'd0);
        chk({tag, "_err_code"}, 32'(err_code), 32'd0);
        chk({tag, "_words"}, 32'(words_loaded), 32'd0);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog expired t=%0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        bq_t        t1, b;
        logic [7:0] j, x, c;
        int         n, nj;
        for (int a = 0; a < W; a++) begin
            em[a] = 32'd0;
            am[a] = 32'd0;
        end
        t1 = '{8'hA5, 8'h02, 8'h00, 8'h93, 8'h02, 8'h50, 8'h00,
               8'h13, 8'h03, 8'hA0, 8'h00, 8'h71};

        #1;
        check_reset_outputs("reset");
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        repeat (2) @(negedge clk);
        chk("idle_core_hold", 32'(core_hold), 32'd1);

        run_frame("t1", t1, 0, 0, -1);

        b = t1;
        b[11] = 8'h70;
        run_frame("t2_csum", b, 0, 0, -1);

        b = '{8'hA5, 8'((W + 1) & 8'hFF), 8'((W + 1) >> 8)};
        run_frame("t3_len", b, 0, 0, -1);

        b = '{8'h00, 8'hFF, 8'h5A};
        foreach (t1[k]) b.push_back(t1[k]);
        run_frame("t4_junk", b, 0, 0, -1);

        b = {};
        for (int k = 0; k < 8; k++) b.push_back(t1[k]);
        run_frame("t5_partial", b, 0, 0, -1);
        reset_n = 1'b0;
        #1;
        check_reset_outputs("t5_reset");
        chk("t5_pending_writes", 32'(exp_q.size()), 32'd0);
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        repeat (10) @(posedge clk);
        #1;
        chk("t5_idle_busy", 32'(busy), 32'd0);
        for (int a = 0; a < W; a++) chk("t5_mem", am[a], em[a]);

        run_frame("t6_gaps", t1, 1, 3, -1);
        run_frame("t6_zero", '{8'hA5, 8'h00, 8'h00, 8'h00}, 0, 0, -1);

        for (int r = 0; r < 20; r++) begin
            b  = {};
            nj = int'($urandom_range(3, 0));
            for (int k = 0; k < nj; k++) begin
                do j = 8'($urandom); while (j == 8'hA5);
                b.push_back(j);
            end
            b.push_back(8'hA5);
            if ($urandom_range(5, 0) == 0) begin
                n = ($urandom_range(1, 0) == 0) ? W + 1 + int'($urandom_range(3, 0))
                                                  : 256 + int'($urandom_range(15, 0));
                b.push_back(8'(n & 255));
                b.push_back(8'(n >> 8));
            end else begin
                n = int'($urandom_range(W, 0));
                b.push_back(8'(n));
                b.push_back(8'h00);
                x = 8'd0;
                for (int k = 0; k < 4 * n; k++) begin
                    c = 8'($urandom);
                    x ^= c;
                    b.push_back(c);
                end
                if ($urandom_range(3, 0) == 0) x ^= 8'($urandom_range(255, 1));
                b.push_back(x);
            end
            run_frame("rand", b, 0, 2, ($urandom_range(3, 0) == 0) ? nj + 1 : -1);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/prog_loader.md
Name: prog_loader

Overview:
- Hardware program loader; the write-side counterpart of the bench's backdoor imem load and register/memory checks.
- Accepts a framed byte stream from a host, such as a UART RX or debug bridge, over valid/ready.
- Assembles little-endian 32-bit instruction words, writes them into mem_ctrl's instruction memory, pads the unused remainder with NOP_INSTR, and verifies a checksum.
- Holds riscv_pipelined_core in reset until a load completes cleanly.

Parameters:
- IMEM_WORDS, IMEM_SIZE (riscv_pkg): instruction memory depth in 32-bit words.
- ADDR_W, $clog2(IMEM_WORDS): word-address width of the imem write port.
- SYNC_BYTE, 8'hA5: frame start marker.

Ports:
- clk  in  1  system clock
- reset_n  in  1  asynchronous, active-low reset
- start  in  1  one-cycle pulse; begin a new load; honoured in IDLE/DONE/ERROR only
- s_valid  in  1  host byte valid
- s_data  in  8  host byte
- s_ready  out  1  loader accepts byte; transfer when s_valid && s_ready
- imem_we  out  1  imem word write strobe
- imem_addr  out  ADDR_W  word address
- imem_wdata  out  32  instruction word
- core_hold  out  1  active-high reset request to the core
- busy  out  1  state not IDLE/DONE/ERROR
- done  out  1  load completed with checksum OK
- err  out  1  load aborted
- err_code  out  2  01 = length overflow, 10 = checksum mismatch, 00 = none
- words_loaded  out  ADDR_W+1  payload words written in the current/last load

Behaviour:
- Frame format: SYNC_BYTE, LEN_LO, LEN_HI (16-bit word count N), then N×4 payload bytes (little-endian per word), then CSUM. CSUM is the XOR of all payload bytes only.
- Reset (reset_n=0, asynchronous):
  - state=IDLE, core_hold=1, s_ready=0, imem_we=0.
  - imem_addr=0, imem_wdata=0, done=0, err=0, err_code=0, words_loaded=0.
  - Reset mid-load aborts immediately; no further writes occur.
- States and transitions:
  - IDLE: s_ready=0. start → SYNC; clears done/err/err_code/words_loaded/checksum.
  - SYNC: s_ready=1. Bytes other than SYNC_BYTE are consumed and discarded. SYNC_BYTE → LEN0.
  - LEN0: latch low byte → LEN1.
  - LEN1: latch high byte. If N > IMEM_WORDS → ERROR (err_code=01). If N==0 → CSUM. Otherwise → DATA.
  - DATA: 2-bit byte counter shifts bytes into a word (byte 0 → bits 7:0). On the 4th byte:
    - imem_we=1 for exactly one cycle on the next clock, with imem_addr = word index and imem_wdata = assembled word.
    - words_loaded increments.
    - After word N-1 → CSUM.
  - CSUM: accept one byte. Equal to the running XOR → FILL. Otherwise → ERROR (err_code=10); words already written are not undone.
  - FILL: s_ready=0. One write per cycle of NOP_INSTR at addresses N..IMEM_WORDS-1. After the last address → DONE. If N==IMEM_WORDS, go → DONE with no fill writes.
  - DONE: done=1, core_hold=0. start → SYNC with core_hold=1 and done=0 in the same cycle.
  - ERROR: err=1, core_hold=1. start → SYNC.
- s_ready is combinational from state: 1 in SYNC/LEN0/LEN1/DATA/CSUM, else 0. Gaps on s_valid are tolerated with no timeout.
- Simultaneous start while busy is ignored.
- core_hold stays 1 from reset until the first DONE.
- Latency: the last CSUM byte is followed by (IMEM_WORDS-N) FILL cycles; done rises on the following cycle.

Decomposition:
- riscv_pkg gains:
  - loader_state_t enum
  - LOADER_SYNC_BYTE
  - LOADER_ERR_LEN = 2'b01
  - LOADER_ERR_CSUM = 2'b10
- The module reuses IMEM_SIZE and NOP_INSTR from riscv_pkg.
- One sub-module is natural: loader_word_asm, the byte→word shift register with a 2-bit counter and a word_valid pulse.
- FSM, checksum, and address counters stay in prog_loader.

Test Plan:
1. start; send A5 02 00 93 02 50 00 13 03 A0 00 71 → imem[0]=0x00500293, imem[1]=0x00A00313, imem[2..IMEM_WORDS-1]=0x00000013; done=1, core_hold=0, words_loaded=2, err=0.
2. Same frame with CSUM=70 → err=1, err_code=10, core_hold=1; imem[0..1] written, imem[2] not overwritten by fill; done=0.
3. Send A5 with LEN = IMEM_WORDS+1 → ERROR right after LEN_HI with err_code=01; zero imem_we pulses.
4. Send 00 FF 5A before the frame of test 1 → the three bytes are discarded; result identical to test 1.
5. Deassert reset_n after 5 payload bytes of test 1 → all outputs at reset values immediately; only imem[0] was written; no further imem_we.
6. Test 1 with s_valid low for 3 random cycles between every byte, then start again from DONE with N=0 and CSUM 00 → identical first result; second load fills imem[0..] with NOP, and core_hold pulses 1 until the second done.
